pixel_dibit_serializer: RTL and testbench

Parametrised successor to the single-pixel dibit sender. Reads a run of NUM_PX pixels from frame BRAM starting at a base address. Compensates the BRAM read latency with a tracked read pipeline and a one-word prefetch buffer. Serialises each pixel into OUT_W-bit symbols for the Ethernet/RMII transmit path, in selectable bit order, with stall back-pressure and start/done control.

---
 rtl/pixel_dibit_serializer_if.sv | 29 ++
 rtl/pixel_dibit_serializer.sv | 126 ++++++++++++
 tb/tb_pixel_dibit_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_dibit_serializer_if.sv
// Bundle of control, BRAM-read and symbol-stream signals for the pixel dibit serializer.
interface pixel_dibit_serializer_if #(
    parameter int PIXEL_W = 8,
    parameter int OUT_W   = 2,
    parameter int ADDR_W  = 24,
    parameter int CNT_W   = 24
);
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic [CNT_W-1:0]   num_px;
    logic               msb_first;
    logic               stall;
    logic [PIXEL_W-1:0] pixel;
    logic [ADDR_W-1:0]  pixel_addr;
    logic               axiov;
    logic [OUT_W-1:0]   axiod;
    logic               busy;
    logic               done;

    modport master (
        output start, base_addr, num_px, msb_first, stall, pixel,
        input  pixel_addr, axiov, axiod, busy, done
    );

    modport slave (
        input  start, base_addr, num_px, msb_first, stall, pixel,
        output pixel_addr, axiov, axiod, busy, done
    );
endinterface

// File: rtl/pixel_dibit_serializer.sv
// Reads NUM_PX pixels from frame BRAM and streams them out as OUT_W-bit symbols,
// hiding the BRAM read latency behind a one-word prefetch buffer.
module pixel_dibit_serializer #(
    parameter int PIXEL_W  = 8,
    parameter int OUT_W    = 2,
    parameter int ADDR_W   = 24,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    pixel_dibit_serializer_if.slave bus
);
    localparam int SYM_N  = PIXEL_W / OUT_W;
    localparam int SCNT_W = $clog2(SYM_N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [READ_LAT:0]  rd_pipe_q, rd_pipe_d;
    logic [PIXEL_W-1:0] pf_q, pf_d;
    logic               pf_full_q, pf_full_d;
    logic [PIXEL_W-1:0] sreg_q, sreg_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               msb_q, msb_d;

    logic start_ok, start_run, issue, load, shift_out, last_sym;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            remain_q  <= '0;
            rd_pipe_q <= '0;
            pf_q      <= '0;
            pf_full_q <= 1'b0;
            sreg_q    <= '0;
            scnt_q    <= '0;
            msb_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            rd_pipe_q <= rd_pipe_d;
            pf_q      <= pf_d;
            pf_full_q <= pf_full_d;
            sreg_q    <= sreg_d;
            scnt_q    <= scnt_d;
            msb_q     <= msb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (bus.num_px == '0) ? S_DONE : S_RUN;
            S_RUN:   if (remain_q == '0) state_d = S_FLUSH;
            S_FLUSH: if (last_sym) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bit 0 of rd_pipe marks the cycle the address is on the bus; the top bit marks returned data.
    always_comb begin
        start_ok  = (state_q == S_IDLE) && bus.start;
        start_run = start_ok && (bus.num_px != '0);
        shift_out = (scnt_q != '0) && !bus.stall;
        load      = pf_full_q && !bus.stall && (scnt_q <= SCNT_W'(1));
        issue     = (state_q == S_RUN) && (rd_pipe_q == '0) && (!pf_full_q || load)
                    && (remain_q != '0);
        last_sym  = (rd_pipe_q == '0) && !pf_full_q && (scnt_q == SCNT_W'(1)) && !bus.stall;

        rd_pipe_d = {rd_pipe_q[READ_LAT-1:0], start_run || issue};

        addr_d   = addr_q;
        remain_d = remain_q;
        if (start_run) begin
            addr_d   = bus.base_addr;
            remain_d = bus.num_px - CNT_W'(1);
        end else if (issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - CNT_W'(1);
        end

        msb_d = start_ok ? bus.msb_first : msb_q;

        pf_d      = pf_q;
        pf_full_d = pf_full_q;
        if (rd_pipe_q[READ_LAT]) begin
            pf_d      = bus.pixel;
            pf_full_d = 1'b1;
        end else if (load) begin
            pf_full_d = 1'b0;
        end

        // The final symbol is left in place so axiod holds while the stream idles.
        sreg_d = sreg_q;
        scnt_d = scnt_q;
        if (load) begin
            sreg_d = pf_q;
            scnt_d = SCNT_W'(SYM_N);
        end else if (shift_out) begin
            scnt_d = scnt_q - SCNT_W'(1);
            if (scnt_q != SCNT_W'(1)) begin
                sreg_d = msb_q ? (sreg_q << OUT_W) : (sreg_q >> OUT_W);
            end
        end
    end

    always_comb begin
        bus.pixel_addr = addr_q;
        bus.axiov      = shift_out;
        bus.axiod      = msb_q ? sreg_q[PIXEL_W-1 -: OUT_W] : sreg_q[OUT_W-1:0];
        bus.busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
        bus.done       = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_pixel_dibit_serializer.sv
// Directed bench for pixel_dibit_serializer with a latency-2 BRAM model and hand-computed symbol streams.
module tb_pixel_dibit_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    pixel_dibit_serializer_if #(.PIXEL_W(8), .OUT_W(2), .ADDR_W(24), .CNT_W(24)) bus ();

    pixel_dibit_serializer #(
        .PIXEL_W(8), .OUT_W(2), .ADDR_W(24), .READ_LAT(2), .CNT_W(24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];
    logic [7:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= mem[bus.pixel_addr[3:0]];
        p2 <= p1;
    end
    assign bus.pixel = p2;

    int n_cmp = 0;
    int n_err = 0;

    int          q_sym[$];
    int          q_cyc[$];
    int          q_addr[$];
    int          exp_sym[$];
    int          start_cyc, done_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [23:0] base, input logic [23:0] n, input logic msb,
                       input int stall_at, input int stall_len);
        int   stall_left;
        logic stalled_once;
        logic got_done;
        q_sym.delete();
        q_cyc.delete();
        q_addr.delete();
        stall_left   = 0;
        stalled_once = 1'b0;
        got_done     = 1'b0;
        done_cyc     = 0;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_px    = n;
        bus.msb_first = msb;
        @(posedge clk);
        #1;
        start_cyc     = cyc;
        bus.start     = 1'b0;
        bus.msb_first = ~msb;
        for (int k = 0; k < 200 && !got_done; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_after_start", 32'(bus.busy), 32'(n != 0));
            if (q_addr.size() == 0 || int'(bus.pixel_addr) != q_addr[$])
                q_addr.push_back(int'(bus.pixel_addr));
            if (stall_left > 0) begin
                check("stall_axiov", 32'(bus.axiov), 32'd0);
                check("stall_axiod_hold", 32'(bus.axiod), 32'(exp_sym[stall_at-1]));
            end
            if (bus.axiov) begin
                q_sym.push_back(int'(bus.axiod));
                q_cyc.push_back(cyc);
            end
            if (bus.done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bus.stall = 1'b0;
            end else if (stall_at >= 0 && !stalled_once && q_sym.size() == stall_at) begin
                bus.stall    = 1'b1;
                stall_left   = stall_len;
                stalled_once = 1'b1;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        @(negedge clk);
        check("idle_after_done", 32'({bus.busy, bus.done}), 32'd0);
    endtask

    task automatic verify(input string tag, input int exp_span);
        check({tag, "_count"}, 32'(q_sym.size()), 32'(exp_sym.size()));
        for (int i = 0; i < exp_sym.size() && i < q_sym.size(); i++)
            check($sformatf("%s_sym%0d", tag, i), 32'(q_sym[i]), 32'(exp_sym[i]));
        if (q_sym.size() > 0) begin
            check({tag, "_latency"}, 32'(q_cyc[0] - start_cyc), 32'd4);
            check({tag, "_span"}, 32'(q_cyc[$] - q_cyc[0]), 32'(exp_span));
            check({tag, "_done_gap"}, 32'(done_cyc - q_cyc[$]), 32'd1);
        end
    endtask

    initial begin
        int   cnt;
        logic saw_done;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'hE4;
        mem[1]  = 8'h55;
        mem[2]  = 8'hE4;
        mem[15] = 8'h1B;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_px    = '0;
        bus.msb_first = 1'b0;
        bus.stall     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_pixel_addr", 32'(bus.pixel_addr), 32'd0);
        check("rst_axiov", 32'(bus.axiov), 32'd0);
        check("rst_axiod", 32'(bus.axiod), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        bus.stall = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_stall_no_valid", 32'(bus.axiov), 32'd0);
        bus.stall = 1'b0;

        exp_sym = '{0, 1, 2, 3};
        run(24'h0, 24'd1, 1'b0, -1, 0);
        verify("lsb", 3);

        exp_sym = '{3, 2, 1, 0};
        run(24'h0, 24'd1, 1'b1, -1, 0);
        verify("msb", 3);

        mem[0] = 8'hAA;
        mem[1] = 8'h55;
        exp_sym = '{2, 2, 2, 2, 1, 1, 1, 1};
        run(24'h0, 24'd2, 1'b0, -1, 0);
        verify("two_px", 7);
        check("two_px_naddr", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            check("two_px_addr0", 32'(q_addr[0]), 32'd0);
            check("two_px_addr1", 32'(q_addr[1]), 32'd1);
        end

        mem[0] = 8'hE4;
        exp_sym = '{0, 1, 2, 3};
        run(24'h0, 24'd1, 1'b0, 2, 3);
        verify("stall", 6);

        exp_sym = '{3, 2, 1, 0, 0, 1, 2, 3};
        run(24'hFFFFFF, 24'd2, 1'b0, -1, 0);
        verify("wrap", 7);
        check("wrap_naddr", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            check("wrap_addr0", 32'(q_addr[0]), 32'h00FFFFFF);
            check("wrap_addr1", 32'(q_addr[1]), 32'h0);
        end

        exp_sym.delete();
        run(24'h7, 24'd0, 1'b0, -1, 0);
        verify("zero", 0);
        check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd0);
        check("zero_naddr", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) check("zero_addr_kept", 32'(q_addr[0]), 32'd0);

        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 24'd2;
        bus.num_px    = 24'd3;
        bus.msb_first = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 2; k++) begin
            @(negedge clk);
            if (bus.axiov) cnt++;
        end
        check("mid_reset_reached", 32'(cnt), 32'd2);
        rst = 1'b0;
        #1;
        check("mid_rst_axiov", 32'(bus.axiov), 32'd0);
        check("mid_rst_axiod", 32'(bus.axiod), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_addr", 32'(bus.pixel_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.axiov || bus.busy) saw_done = 1'b1;
        end
        check("post_rst_quiet", 32'(saw_done), 32'd0);

        exp_sym = '{1, 1, 1, 1};
        run(24'h1, 24'd1, 1'b0, -1, 0);
        verify("after_rst", 3);
        check("after_rst_addr", 32'(q_addr[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
